bus_serial_slave: RTL and testbench
===================================

// Module: bus_serial_slave
// PURPOSE
//  Responder end of the bit-serial system bus driven by the master ports through the arbiter.
//  Deserialises address and write data, commits writes to local storage, and serialises read data back.
//  Sits behind the arbiter as one of the slave slots (S1..S3). The top level instantiates it once per slave.
//  Exposes a 3-bit state for the board LEDs.
// PARAMETERS
//  ADDR_WIDTH    12  serial address bits per transaction; the low MEM_ADDR_WIDTH bits index storage
//  MEM_ADDR_WIDTH 4  local storage depth = 2**MEM_ADDR_WIDTH words
//  DATA_WIDTH     8  data word width
//  READ_LATENCY   2  wait cycles between the last address bit and the first read-data bit (>=1)
// PORTS
//  clk          in   1           system clock (divided board clock)
//  reset        in   1           asynchronous, active-low reset
//  m_valid      in   1           transaction start strobe from the granted master, 1 cycle
//  m_mode       in   1           sampled with m_valid: 1=write, 0=read
//  m_sdata      in   1           serial address/write data, LSB first
//  s_ready      out  1           high only in IDLE: slave can accept m_valid
//  s_valid      out  1           high while s_sdata carries read data
//  s_sdata      out  1           serial read data, LSB first; 0 when s_valid=0
//  s_ack        out  1           1-cycle pulse when a write commits or a read's last bit is sent
//  slave_state  out  3           current FSM encoding (LED display)
// BEHAVIOUR
//  - Reset (reset=0, async): FSM=IDLE, counters/shift regs=0, s_ready=1, s_valid=0, s_sdata=0, s_ack=0.
//    Storage contents are not cleared. Reset mid-transaction drops it with no write and no ack.
//  - FSM encodings: IDLE=0, RX_ADDR=1, RX_DATA=2, WRITE=3, WAIT=4, TX_DATA=5.
//  - IDLE: m_valid=1 -> latch m_mode, clear bit counter, go to RX_ADDR. m_sdata is ignored on the m_valid cycle.
//  - RX_ADDR: shift m_sdata into addr, LSB first, for exactly ADDR_WIDTH cycles.
//    After the last bit: write -> RX_DATA; read -> WAIT.
//  - RX_DATA: shift DATA_WIDTH bits into wdata, LSB first, then go to WRITE.
//  - WRITE: 1 cycle. mem[addr[MEM_ADDR_WIDTH-1:0]] <= wdata, s_ack=1, then IDLE.
//  - WAIT: READ_LATENCY cycles. Load the tx shift reg from mem on the first WAIT cycle. Then TX_DATA.
//  - TX_DATA: s_valid=1 for DATA_WIDTH cycles. s_sdata = tx[0], shifting right each cycle.
//    s_ack=1 on the last bit cycle, then IDLE.
//  - Read latency: 1 (m_valid) + ADDR_WIDTH + READ_LATENCY cycles from the m_valid edge to the first data bit.
//  - Write occupancy: 1 + ADDR_WIDTH + DATA_WIDTH + 1 cycles. s_ready returns high the cycle after WRITE.
//  - m_valid while not IDLE: ignored, with no effect on the transaction in progress.
//  - m_valid in the cycle the FSM returns to IDLE: not accepted; s_ready was 0 at that edge.
//  - Address bits above MEM_ADDR_WIDTH are captured but ignored (alias/wrap). Address decode belongs to the arbiter.
//  - Bit counter width $clog2(max(ADDR_WIDTH,DATA_WIDTH,READ_LATENCY)+1). It clears on every state change.
//  - Outputs are registered, except s_ready and slave_state, which decode directly from the FSM register.
// STRUCTURE
//  - Shared package bus_pkg: FSM state localparams, default ADDR_WIDTH/DATA_WIDTH, mode encodings (BUS_WRITE=1, BUS_READ=0).
//    The master-side block uses the same package.
//  - One sub-module, serial_shift_reg (WIDTH, DIR, load, shift_en, sin, sout, q).
//    Instantiated for addr RX, wdata RX and tx data.
//  - Storage is an inferred register array in this module.
// TESTING
//  1. Reset: assert reset=0 mid-RX_ADDR -> all outputs at reset values immediately.
//     After release, slave_state=0 and s_ready=1.
//  2. Write then read: write addr 0x005, data 0xA7 -> s_ack pulse at cycle 1+12+8+1.
//     Read addr 0x005 -> s_valid for 8 cycles, serial bits 1,1,1,0,0,1,0,1, s_ack on the 8th bit.
//  3. Aliasing: write 0x3C to addr 0x013, read addr 0x003 -> returns 0x3C (MEM_ADDR_WIDTH=4).
//  4. Busy: pulse m_valid during RX_DATA and TX_DATA -> no state change, data intact, single s_ack.
//  5. Back-to-back: m_valid on the cycle after s_ack -> accepted. Same cycle as s_ack -> ignored.
//  6. Latency: READ_LATENCY=3 build -> first s_valid exactly 1+12+3 cycles after m_valid.
//     An unwritten location after reset returns a stable value without X on s_sdata when the memory is preloaded to 0 in sim.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bit-serial system bus: slave FSM encodings, mode codes and defaults.
package bus_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 12;
    localparam int unsigned BUS_DATA_WIDTH = 8;

    localparam logic BUS_WRITE = 1'b1;
    localparam logic BUS_READ  = 1'b0;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRxAddr = 3'd1,
        StRxData = 3'd2,
        StWrite  = 3'd3,
        StWait   = 3'd4,
        StTxData = 3'd5
    } slave_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Loadable serial shift register; DIR=0 shifts right (sin enters MSB), DIR=1 shifts left.
module serial_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter bit          DIR   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_en_i,
    input  logic             sin_i,
    output logic             sout_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_data_i;
        end else if (shift_en_i) begin
            q_d = (DIR == 1'b0) ? {sin_i, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], sin_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign sout_o = (DIR == 1'b0) ? q_q[0] : q_q[WIDTH-1];
    assign q_o    = q_q;

endmodule

// File: rtl/bus_serial_slave.sv
// Bit-serial bus slave: receives address/write data LSB first, stores writes locally,
// and streams read data back after a fixed latency.
module bus_serial_slave
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = BUS_ADDR_WIDTH,
    parameter int unsigned MEM_ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH     = BUS_DATA_WIDTH,
    parameter int unsigned READ_LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m_valid,
    input  logic       m_mode,
    input  logic       m_sdata,
    output logic       s_ready,
    output logic       s_valid,
    output logic       s_sdata,
    output logic       s_ack,
    output logic [2:0] slave_state
);

    localparam int unsigned CntWidth = $clog2(max3(ADDR_WIDTH, DATA_WIDTH, READ_LATENCY) + 1);

    slave_state_e          state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic                  s_valid_q, s_valid_d;
    logic                  s_sdata_q, s_sdata_d;
    logic                  s_ack_q, s_ack_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, tx_q, rdata;
    logic                  tx_load, tx_shift;
    logic                  addr_sout, wdata_sout, tx_sout;

    logic [DATA_WIDTH-1:0]     mem_q [2**MEM_ADDR_WIDTH];
    logic [MEM_ADDR_WIDTH-1:0] mem_idx;

    // Upper address bits alias onto storage; they are captured but never decoded here.
    logic unused_bits;
    assign unused_bits = ^{addr_q, tx_q, addr_sout, wdata_sout, tx_sout};

    assign mem_idx = addr_q[MEM_ADDR_WIDTH-1:0];
    assign rdata   = mem_q[mem_idx];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (m_valid) state_d = StRxAddr;
            StRxAddr: if (cnt_q == CntWidth'(ADDR_WIDTH - 1)) begin
                state_d = (mode_q == BUS_WRITE) ? StRxData : StWait;
            end
            StRxData: if (cnt_q == CntWidth'(DATA_WIDTH - 1)) state_d = StWrite;
            StWrite:  state_d = StIdle;
            StWait:   if (cnt_q == CntWidth'(READ_LATENCY - 1)) state_d = StTxData;
            StTxData: if (cnt_q == CntWidth'(DATA_WIDTH - 1)) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d  = '0;
        mode_d = mode_q;
        if (state_q == StIdle) begin
            if (m_valid) mode_d = m_mode;
        end else if (state_d == state_q) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    assign tx_load  = (state_q == StWait) && (cnt_q == '0);
    assign tx_shift = (state_q == StTxData);

    // Outputs are registered but aligned with the state they belong to, so the next
    // serial bit is chosen from whatever the tx register will hold after this edge.
    always_comb begin
        s_valid_d = (state_d == StTxData);
        s_sdata_d = 1'b0;
        if (s_valid_d) begin
            if (tx_load) begin
                s_sdata_d = rdata[0];
            end else if (tx_shift) begin
                s_sdata_d = tx_q[1];
            end else begin
                s_sdata_d = tx_q[0];
            end
        end
        s_ack_d = (state_d == StWrite) ||
                  ((state_d == StTxData) && (cnt_d == CntWidth'(DATA_WIDTH - 1)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mode_q    <= BUS_READ;
            s_valid_q <= 1'b0;
            s_sdata_q <= 1'b0;
            s_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            s_valid_q <= s_valid_d;
            s_sdata_q <= s_sdata_d;
            s_ack_q   <= s_ack_d;
        end
    end

    // Storage deliberately has no reset.
    always_ff @(posedge clk) begin
        if (state_q == StWrite) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    serial_shift_reg #(.WIDTH(ADDR_WIDTH), .DIR(1'b0)) u_addr_sr (
        .clk_i       (clk),
        .rst_ni      (reset),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_en_i  (state_q == StRxAddr),
        .sin_i       (m_sdata),
        .sout_o      (addr_sout),
        .q_o         (addr_q)
    );

    serial_shift_reg #(.WIDTH(DATA_WIDTH), .DIR(1'b0)) u_wdata_sr (
        .clk_i       (clk),
        .rst_ni      (reset),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_en_i  (state_q == StRxData),
        .sin_i       (m_sdata),
        .sout_o      (wdata_sout),
        .q_o         (wdata_q)
    );

    serial_shift_reg #(.WIDTH(DATA_WIDTH), .DIR(1'b0)) u_tx_sr (
        .clk_i       (clk),
        .rst_ni      (reset),
        .load_i      (tx_load),
        .load_data_i (rdata),
        .shift_en_i  (tx_shift),
        .sin_i       (1'b0),
        .sout_o      (tx_sout),
        .q_o         (tx_q)
    );

    assign s_ready     = (state_q == StIdle);
    assign slave_state = state_q;
    assign s_valid     = s_valid_q;
    assign s_sdata     = s_sdata_q;
    assign s_ack       = s_ack_q;

endmodule

// File: tb/tb_bus_serial_slave.sv
// Directed + randomized bench for bus_serial_slave against a word-level memory model.
module tb_bus_serial_slave;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_RXA = 3'd1, S_RXD = 3'd2, S_WR = 3'd3,
                           S_WAIT = 3'd4, S_TX = 3'd5;

    logic clk, reset, mv, sel, m_mode, m_sdata;
    logic mv_a, mv_b;
    logic rdy_a, val_a, sd_a, ack_a, rdy_b, val_b, sd_b, ack_b;
    logic [2:0] st_a, st_b;
    logic o_ready, o_valid, o_sdata, o_ack;
    logic [2:0] o_state;

    int n_vec, n_fail;
    logic [7:0] model [2][16];
    bit written [2][16];

    assign mv_a    = mv & ~sel;
    assign mv_b    = mv & sel;
    assign o_ready = sel ? rdy_b : rdy_a;
    assign o_valid = sel ? val_b : val_a;
    assign o_sdata = sel ? sd_b : sd_a;
    assign o_ack   = sel ? ack_b : ack_a;
    assign o_state = sel ? st_b : st_a;

    bus_serial_slave u_dut (
        .clk(clk), .reset(reset), .m_valid(mv_a), .m_mode(m_mode), .m_sdata(m_sdata),
        .s_ready(rdy_a), .s_valid(val_a), .s_sdata(sd_a), .s_ack(ack_a), .slave_state(st_a)
    );

    bus_serial_slave #(.READ_LATENCY(3)) u_dut_rl3 (
        .clk(clk), .reset(reset), .m_valid(mv_b), .m_mode(m_mode), .m_sdata(m_sdata),
        .s_ready(rdy_b), .s_valid(val_b), .s_sdata(sd_b), .s_ack(ack_b), .slave_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic mode);
        check("idle_state", 32'(o_state), 32'(S_IDLE));
        check("idle_ready", 32'(o_ready), 1);
        mv      = 1'b1;
        m_mode  = mode;
        m_sdata = 1'($urandom);
        @(negedge clk);
        mv     = 1'b0;
        m_mode = 1'($urandom);
    endtask

    task automatic send_addr(input logic [AW-1:0] a);
        for (int i = 0; i < AW; i++) begin
            check("rxa_state", 32'(o_state), 32'(S_RXA));
            check("rxa_ready", 32'(o_ready), 0);
            check("rxa_ack", 32'(o_ack), 0);
            m_sdata = a[i];
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int busy,
                            input logic ack_pulse);
        start(1'b1);
        send_addr(a);
        for (int j = 0; j < DW; j++) begin
            check("rxd_state", 32'(o_state), 32'(S_RXD));
            check("rxd_ack", 32'(o_ack), 0);
            m_sdata = d[j];
            mv      = (j == busy);
            @(negedge clk);
        end
        mv = 1'b0;
        check("wr_state", 32'(o_state), 32'(S_WR));
        check("wr_ack", 32'(o_ack), 1);
        check("wr_valid", 32'(o_valid), 0);
        mv = ack_pulse;
        @(negedge clk);
        mv = 1'b0;
        model[sel][a[3:0]]   = d;
        written[sel][a[3:0]] = 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int busy, input logic ack_pulse);
        int rl, lat;
        logic [DW-1:0] exp;
        rl  = sel ? 3 : 2;
        exp = model[sel][a[3:0]];
        start(1'b0);
        send_addr(a);
        lat = 1 + AW;
        for (int w = 0; w < rl; w++) begin
            check("wait_state", 32'(o_state), 32'(S_WAIT));
            check("wait_valid", 32'(o_valid), 0);
            check("wait_sdata", 32'(o_sdata), 0);
            @(negedge clk);
            lat++;
        end
        check("rd_latency", 32'(lat), 32'(1 + AW + rl));
        for (int j = 0; j < DW; j++) begin
            check("tx_state", 32'(o_state), 32'(S_TX));
            check("tx_valid", 32'(o_valid), 1);
            check("tx_bit", 32'(o_sdata), 32'(exp[j]));
            check("tx_ack", 32'(o_ack), (j == DW - 1) ? 1 : 0);
            mv = (j == busy) || ((j == DW - 1) && ack_pulse);
            @(negedge clk);
        end
        mv = 1'b0;
        check("post_valid", 32'(o_valid), 0);
        check("post_ack", 32'(o_ack), 0);
    endtask

    task automatic pick_written(output logic [AW-1:0] a);
        logic [3:0] lo;
        logic [7:0] hi;
        do lo = 4'($urandom_range(15, 0)); while (!written[sel][lo]);
        hi = 8'($urandom_range(255, 0));
        a  = {hi, lo};
    endtask

    initial begin
        logic [AW-1:0] a;
        n_vec   = 0;
        n_fail  = 0;
        mv      = 1'b0;
        sel     = 1'b0;
        m_mode  = 1'b0;
        m_sdata = 1'b0;
        reset   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(o_state), 32'(S_IDLE));
        check("rst_ready", 32'(o_ready), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_ack", 32'(o_ack), 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic write/read and LSB-first serialisation.
        do_write(12'h005, 8'hA7, -1, 1'b0);
        do_read(12'h005, -1, 1'b0);

        // Upper address bits alias onto the 16-word store.
        do_write(12'h013, 8'h3C, -1, 1'b0);
        do_read(12'h003, -1, 1'b0);

        // Stray m_valid pulses while busy.
        do_write(12'h2A9, 8'h5E, 3, 1'b0);
        do_read(12'h2A9, 4, 1'b0);

        // m_valid coinciding with s_ack is dropped; the next cycle is accepted.
        do_write(12'h7F1, 8'hC3, -1, 1'b1);
        check("ackpulse_idle", 32'(o_state), 32'(S_IDLE));
        @(negedge clk);
        do_read(12'h001, -1, 1'b1);
        check("ackpulse_rd_idle", 32'(o_state), 32'(S_IDLE));
        @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            int busy;
            busy = int'($urandom_range(9, 0)) - 1;
            if ($urandom_range(1, 0) == 1) begin
                do_write(12'($urandom), 8'($urandom), busy, 1'($urandom));
            end else begin
                pick_written(a);
                do_read(a, busy, 1'($urandom));
            end
            @(negedge clk);
        end

        // Asynchronous reset mid-address drops the write.
        start(1'b1);
        for (int i = 0; i < 5; i++) begin
            m_sdata = 1'(12'h005 >> i);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        check("midrst_state", 32'(o_state), 32'(S_IDLE));
        check("midrst_ready", 32'(o_ready), 1);
        check("midrst_valid", 32'(o_valid), 0);
        check("midrst_sdata", 32'(o_sdata), 0);
        check("midrst_ack", 32'(o_ack), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_read(12'h005, -1, 1'b0);

        // READ_LATENCY=3 instance.
        sel = 1'b1;
        @(negedge clk);
        do_write(12'h10A, 8'h96, -1, 1'b0);
        do_write(12'h00B, 8'h4D, -1, 1'b0);
        do_read(12'h00A, -1, 1'b0);
        do_read(12'hF0B, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
